// File: rtl/victim_cache_ctrl_pkg.sv
// Shared types for the L1 miss sequencer: FSM state encoding and refill source codes.
// Pure declarations; no latency or backpressure of its own.
package RVS192_package;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        VC_REFILL = 3'd1,
        L2_FETCH  = 3'd2,
        WB        = 3'd3,
        INSERT    = 3'd4,
        DONE      = 3'd5
    } vcc_state_e;

    localparam logic REFILL_SRC_L2 = 1'b0;
    localparam logic REFILL_SRC_VC = 1'b1;

    // Where to go once the L1 line has been refilled: a dirty victim goes through L2 first,
    // a clean victim goes straight into the VC, and with no victim there is nothing to insert.
    function automatic vcc_state_e after_refill(input logic victim_valid, input logic victim_dirty);
        if (victim_valid && victim_dirty) begin
            return WB;
        end else if (victim_valid) begin
            return INSERT;
        end
        return DONE;
    endfunction

endpackage

// File: rtl/victim_cache_ctrl_swap_buffer.sv
// Swap buffer holding the evicted L1 line (tag + data) while L1 is refilled.
// Loads in one cycle on load_en; no backpressure, contents held until the next load or reset.
module vc_swap_buffer #(
    parameter int SLOT         = 4,
    parameter int DATA_LENGTH  = 32,
    parameter int VCTAG_LENGTH = 26
) (
    input  logic                          clk_l1,
    input  logic                          rst_n,
    input  logic                          load_en,
    input  logic [VCTAG_LENGTH-1:0]       tag_in,
    input  logic [SLOT*DATA_LENGTH-1:0]   data_in,
    output logic [VCTAG_LENGTH-1:0]       tag_out,
    output logic [SLOT*DATA_LENGTH-1:0]   data_out
);

    logic [VCTAG_LENGTH-1:0]     tag_q,  tag_d;
    logic [SLOT*DATA_LENGTH-1:0] data_q, data_d;

    always_comb begin
        tag_d  = tag_q;
        data_d = data_q;
        if (load_en) begin
            tag_d  = tag_in;
            data_d = data_in;
        end
    end

    always_ff @(posedge clk_l1 or negedge rst_n) begin
        if (!rst_n) begin
            tag_q  <= '0;
            data_q <= '0;
        end else begin
            tag_q  <= tag_d;
            data_q <= data_d;
        end
    end

    assign tag_out  = tag_q;
    assign data_out = data_q;

endmodule

// File: rtl/victim_cache_ctrl.sv
// L1 miss sequencer: VC lookup result -> refill (VC or L2) -> dirty writeback -> victim insert -> done.
// VC hit done at +3, L2 refill on l2_ack then done +2 (clean victim); waits indefinitely on l2_ack/wb_ack, ignores miss_req while busy.
module victim_cache_ctrl
    import RVS192_package::*;
#(
    parameter int SLOT         = 4,
    parameter int DATA_LENGTH  = 32,
    parameter int VCTAG_LENGTH = 26,
    parameter int CNT_WIDTH    = 16
) (
    input  logic                          clk_l1,
    input  logic                          rst_n,
    input  logic                          miss_req,
    output logic                          miss_ready,
    input  logic                          victim_valid,
    input  logic                          victim_dirty,
    input  logic [VCTAG_LENGTH-1:0]       victim_tag,
    input  logic [SLOT*DATA_LENGTH-1:0]   victim_data,
    input  logic                          vc_hit,
    output logic                          vc_wen,
    output logic [VCTAG_LENGTH-1:0]       vc_tag_out,
    output logic [SLOT*DATA_LENGTH-1:0]   vc_data_out,
    output logic                          l2_req,
    input  logic                          l2_ack,
    output logic                          wb_req,
    input  logic                          wb_ack,
    output logic                          refill_en,
    output logic                          refill_src,
    output logic                          miss_done,
    output logic [CNT_WIDTH-1:0]          vc_hit_cnt,
    output logic [CNT_WIDTH-1:0]          miss_cnt
);

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    vcc_state_e state_q, state_d;

    logic victim_valid_q, victim_valid_d;
    logic victim_dirty_q, victim_dirty_d;
    logic hit_q,          hit_d;

    logic l2_req_q,     l2_req_d;
    logic wb_req_q,     wb_req_d;
    logic refill_vc_q,  refill_vc_d;
    logic refill_src_q, refill_src_d;
    logic vc_wen_q,     vc_wen_d;
    logic miss_done_q,  miss_done_d;
    logic miss_ready_q, miss_ready_d;

    logic [CNT_WIDTH-1:0] vc_hit_cnt_q, vc_hit_cnt_d;
    logic [CNT_WIDTH-1:0] miss_cnt_q,   miss_cnt_d;

    logic buf_load;
    logic accept;

    assign accept = (state_q == IDLE) && miss_req;

    always_comb begin
        state_d        = state_q;
        victim_valid_d = victim_valid_q;
        victim_dirty_d = victim_dirty_q;
        hit_d          = hit_q;
        vc_hit_cnt_d   = vc_hit_cnt_q;
        miss_cnt_d     = miss_cnt_q;
        buf_load       = 1'b0;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    buf_load       = 1'b1;
                    victim_valid_d = victim_valid;
                    victim_dirty_d = victim_dirty;
                    hit_d          = vc_hit;
                    miss_cnt_d     = (miss_cnt_q == CNT_MAX) ? miss_cnt_q : miss_cnt_q + CNT_ONE;
                    state_d        = vc_hit ? VC_REFILL : L2_FETCH;
                end
            end
            VC_REFILL: begin
                if (hit_q) begin
                    vc_hit_cnt_d = (vc_hit_cnt_q == CNT_MAX) ? vc_hit_cnt_q : vc_hit_cnt_q + CNT_ONE;
                end
                state_d = after_refill(victim_valid_q, victim_dirty_q);
            end
            L2_FETCH: begin
                if (l2_ack) begin
                    state_d = after_refill(victim_valid_q, victim_dirty_q);
                end
            end
            WB: begin
                if (wb_ack) begin
                    state_d = INSERT;
                end
            end
            INSERT:  state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Registered outputs are a pure function of the state being entered.
        l2_req_d     = (state_d == L2_FETCH);
        wb_req_d     = (state_d == WB);
        refill_vc_d  = (state_d == VC_REFILL);
        refill_src_d = (state_d == VC_REFILL) ? REFILL_SRC_VC : REFILL_SRC_L2;
        vc_wen_d     = (state_d == INSERT);
        miss_done_d  = (state_d == DONE);
        miss_ready_d = (state_d == IDLE);
    end

    always_ff @(posedge clk_l1 or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            victim_valid_q <= 1'b0;
            victim_dirty_q <= 1'b0;
            hit_q          <= 1'b0;
            l2_req_q       <= 1'b0;
            wb_req_q       <= 1'b0;
            refill_vc_q    <= 1'b0;
            refill_src_q   <= REFILL_SRC_L2;
            vc_wen_q       <= 1'b0;
            miss_done_q    <= 1'b0;
            miss_ready_q   <= 1'b1;
            vc_hit_cnt_q   <= '0;
            miss_cnt_q     <= '0;
        end else begin
            state_q        <= state_d;
            victim_valid_q <= victim_valid_d;
            victim_dirty_q <= victim_dirty_d;
            hit_q          <= hit_d;
            l2_req_q       <= l2_req_d;
            wb_req_q       <= wb_req_d;
            refill_vc_q    <= refill_vc_d;
            refill_src_q   <= refill_src_d;
            vc_wen_q       <= vc_wen_d;
            miss_done_q    <= miss_done_d;
            miss_ready_q   <= miss_ready_d;
            vc_hit_cnt_q   <= vc_hit_cnt_d;
            miss_cnt_q     <= miss_cnt_d;
        end
    end

    vc_swap_buffer #(
        .SLOT         (SLOT),
        .DATA_LENGTH  (DATA_LENGTH),
        .VCTAG_LENGTH (VCTAG_LENGTH)
    ) u_swap_buffer (
        .clk_l1   (clk_l1),
        .rst_n    (rst_n),
        .load_en  (buf_load),
        .tag_in   (victim_tag),
        .data_in  (victim_data),
        .tag_out  (vc_tag_out),
        .data_out (vc_data_out)
    );

    // The L2 refill strobe has to land in the ack cycle itself, so it cannot be registered.
    assign refill_en  = refill_vc_q | (l2_req_q & l2_ack);
    assign refill_src = refill_src_q;
    assign l2_req     = l2_req_q;
    assign wb_req     = wb_req_q;
    assign vc_wen     = vc_wen_q;
    assign miss_done  = miss_done_q;
    assign miss_ready = miss_ready_q;
    assign vc_hit_cnt = vc_hit_cnt_q;
    assign miss_cnt   = miss_cnt_q;

endmodule

// File: tb/tb_victim_cache_ctrl.sv
// Directed + randomized bench for victim_cache_ctrl; a wide-counter and a 2-bit-counter instance share stimulus.
module tb_victim_cache_ctrl;

    localparam int SLOT = 4;
    localparam int DL   = 32;
    localparam int TL   = 26;
    localparam int LW   = SLOT * DL;

    typedef struct packed {
        logic l2_req;
        logic refill_en;
        logic refill_src;
        logic wb_req;
        logic vc_wen;
        logic miss_done;
        logic l2_ack;
        logic wb_ack;
    } step_t;

    logic          clk;
    logic          rst_n;
    logic          miss_req;
    logic          victim_valid;
    logic          victim_dirty;
    logic [TL-1:0] victim_tag;
    logic [LW-1:0] victim_data;
    logic          vc_hit;
    logic          l2_ack;
    logic          wb_ack;

    logic          a_miss_ready, a_vc_wen, a_l2_req, a_wb_req, a_refill_en, a_refill_src, a_miss_done;
    logic [TL-1:0] a_vc_tag_out;
    logic [LW-1:0] a_vc_data_out;
    logic [15:0]   a_vc_hit_cnt, a_miss_cnt;

    logic          b_miss_ready, b_vc_wen, b_l2_req, b_wb_req, b_refill_en, b_refill_src, b_miss_done;
    logic [TL-1:0] b_vc_tag_out;
    logic [LW-1:0] b_vc_data_out;
    logic [1:0]    b_vc_hit_cnt, b_miss_cnt;

    int checks   = 0;
    int failures = 0;

    // Reference counters: expected values computed from the saturating-count rule.
    int exp_miss_a, exp_hit_a, exp_miss_b, exp_hit_b;

    victim_cache_ctrl #(.SLOT(SLOT), .DATA_LENGTH(DL), .VCTAG_LENGTH(TL), .CNT_WIDTH(16)) dut_a (
        .clk_l1(clk), .rst_n(rst_n), .miss_req(miss_req), .miss_ready(a_miss_ready),
        .victim_valid(victim_valid), .victim_dirty(victim_dirty), .victim_tag(victim_tag),
        .victim_data(victim_data), .vc_hit(vc_hit), .vc_wen(a_vc_wen), .vc_tag_out(a_vc_tag_out),
        .vc_data_out(a_vc_data_out), .l2_req(a_l2_req), .l2_ack(l2_ack), .wb_req(a_wb_req),
        .wb_ack(wb_ack), .refill_en(a_refill_en), .refill_src(a_refill_src), .miss_done(a_miss_done),
        .vc_hit_cnt(a_vc_hit_cnt), .miss_cnt(a_miss_cnt)
    );

    victim_cache_ctrl #(.SLOT(SLOT), .DATA_LENGTH(DL), .VCTAG_LENGTH(TL), .CNT_WIDTH(2)) dut_b (
        .clk_l1(clk), .rst_n(rst_n), .miss_req(miss_req), .miss_ready(b_miss_ready),
        .victim_valid(victim_valid), .victim_dirty(victim_dirty), .victim_tag(victim_tag),
        .victim_data(victim_data), .vc_hit(vc_hit), .vc_wen(b_vc_wen), .vc_tag_out(b_vc_tag_out),
        .vc_data_out(b_vc_data_out), .l2_req(b_l2_req), .l2_ack(l2_ack), .wb_req(b_wb_req),
        .wb_ack(wb_ack), .refill_en(b_refill_en), .refill_src(b_refill_src), .miss_done(b_miss_done),
        .vc_hit_cnt(b_vc_hit_cnt), .miss_cnt(b_miss_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int sat_inc(input int v, input int max);
        return (v >= max) ? max : v + 1;
    endfunction

    // {l2_req, refill_en, wb_req, vc_wen, miss_done, miss_ready}
    function automatic logic [5:0] a_vec();
        return {a_l2_req, a_refill_en, a_wb_req, a_vc_wen, a_miss_done, a_miss_ready};
    endfunction

    function automatic logic [5:0] b_vec();
        return {b_l2_req, b_refill_en, b_wb_req, b_vc_wen, b_miss_done, b_miss_ready};
    endfunction

    task automatic chk_counters(input string ctx);
        chk({ctx, "_a_miss_cnt"},   a_miss_cnt,   exp_miss_a);
        chk({ctx, "_a_vc_hit_cnt"}, a_vc_hit_cnt, exp_hit_a);
        chk({ctx, "_b_miss_cnt"},   b_miss_cnt,   exp_miss_b);
        chk({ctx, "_b_vc_hit_cnt"}, b_vc_hit_cnt, exp_hit_b);
    endtask

    task automatic idle_cycle(input string ctx);
        @(negedge clk);
        miss_req = 1'b0; l2_ack = 1'b0; wb_ack = 1'b0;
        #1;
        chk({ctx, "_idle_a"}, a_vec(), 6'b000001);
        chk({ctx, "_idle_b"}, b_vec(), 6'b000001);
    endtask

    // One complete miss: the expected cycle sequence is derived from the service rules,
    // then walked cycle by cycle driving the acks the plan calls for.
    task automatic run_miss(input string ctx, input logic v, input logic d, input logic h,
                            input logic [TL-1:0] tag, input logic [LW-1:0] data,
                            input int l2_lat, input int wb_lat, input bit junk);
        step_t plan[$];
        step_t s;
        step_t e;
        logic [5:0] exp_vec;

        if (h) begin
            s = '0; s.refill_en = 1'b1; s.refill_src = 1'b1; plan.push_back(s);
        end else begin
            for (int i = 1; i <= l2_lat; i++) begin
                s = '0; s.l2_req = 1'b1; s.l2_ack = (i == l2_lat); s.refill_en = (i == l2_lat);
                plan.push_back(s);
            end
        end
        if (v && d) begin
            for (int i = 1; i <= wb_lat; i++) begin
                s = '0; s.wb_req = 1'b1; s.wb_ack = (i == wb_lat); plan.push_back(s);
            end
        end
        if (v) begin
            s = '0; s.vc_wen = 1'b1; plan.push_back(s);
        end
        s = '0; s.miss_done = 1'b1; plan.push_back(s);

        @(negedge clk);
        miss_req = 1'b1; victim_valid = v; victim_dirty = d; victim_tag = tag;
        victim_data = data; vc_hit = h; l2_ack = 1'b0; wb_ack = 1'b0;
        #1;
        chk({ctx, "_accept_ready"}, a_vec(), 6'b000001);

        for (int c = 0; c < plan.size(); c++) begin
            e = plan[c];
            @(negedge clk);
            miss_req = junk ? 1'($urandom_range(0, 1)) : 1'b0;
            vc_hit   = 1'($urandom_range(0, 1));
            if (junk) begin
                victim_valid = 1'($urandom_range(0, 1));
                victim_dirty = 1'($urandom_range(0, 1));
                victim_tag   = TL'($urandom);
                victim_data  = {$urandom, $urandom, $urandom, $urandom};
            end
            l2_ack = e.l2_req ? e.l2_ack : (junk ? 1'($urandom_range(0, 1)) : 1'b0);
            wb_ack = e.wb_req ? e.wb_ack : (junk && !e.l2_req ? 1'($urandom_range(0, 1)) : 1'b0);
            #1;
            exp_vec = {e.l2_req, e.refill_en, e.wb_req, e.vc_wen, e.miss_done, 1'b0};
            chk($sformatf("%s_cyc%0d_a", ctx, c + 1), a_vec(), exp_vec);
            chk($sformatf("%s_cyc%0d_b", ctx, c + 1), b_vec(), exp_vec);
            if (e.refill_en) chk($sformatf("%s_refill_src", ctx), a_refill_src, e.refill_src);
            if (e.vc_wen) begin
                chk({ctx, "_vc_tag_out"},  a_vc_tag_out,  tag);
                chk({ctx, "_vc_data_out"}, a_vc_data_out, data);
            end
        end

        exp_miss_a = sat_inc(exp_miss_a, 65535);
        exp_miss_b = sat_inc(exp_miss_b, 3);
        if (h) begin
            exp_hit_a = sat_inc(exp_hit_a, 65535);
            exp_hit_b = sat_inc(exp_hit_b, 3);
        end
        idle_cycle(ctx);
        chk_counters(ctx);
    endtask

    initial begin
        logic [LW-1:0] rdata;
        rst_n = 1'b0; miss_req = 1'b0; victim_valid = 1'b0; victim_dirty = 1'b0;
        victim_tag = '0; victim_data = '0; vc_hit = 1'b0; l2_ack = 1'b0; wb_ack = 1'b0;
        exp_miss_a = 0; exp_hit_a = 0; exp_miss_b = 0; exp_hit_b = 0;

        repeat (2) @(negedge clk);
        #1;
        chk("reset_vec_a", a_vec(), 6'b000001);
        chk("reset_refill_src", a_refill_src, 1'b0);
        chk("reset_vc_tag_out", a_vc_tag_out, '0);
        chk("reset_vc_data_out", a_vc_data_out, '0);
        chk_counters("reset");
        @(negedge clk);
        rst_n = 1'b1;

        rdata = {$urandom, $urandom, $urandom, $urandom};
        run_miss("hit_clean", 1'b1, 1'b0, 1'b1, TL'(26'h155), rdata, 1, 1, 1'b0);
        rdata = {$urandom, $urandom, $urandom, $urandom};
        run_miss("l2_dirty", 1'b1, 1'b1, 1'b0, TL'($urandom), rdata, 3, 2, 1'b0);
        run_miss("no_victim", 1'b0, 1'b0, 1'b0, TL'($urandom), rdata, 2, 1, 1'b0);
        rdata = {$urandom, $urandom, $urandom, $urandom};
        run_miss("busy_pulse", 1'b1, 1'b0, 1'b0, TL'($urandom), rdata, 4, 1, 1'b1);
        run_miss("l2_one_cycle", 1'b1, 1'b1, 1'b0, TL'($urandom), rdata, 1, 1, 1'b1);

        // Reset while a writeback handshake is outstanding.
        @(negedge clk);
        miss_req = 1'b1; victim_valid = 1'b1; victim_dirty = 1'b1; vc_hit = 1'b0;
        victim_tag = TL'($urandom);
        @(negedge clk);
        miss_req = 1'b0; l2_ack = 1'b1;
        #1 chk("rst_pre_fetch", a_vec(), 6'b110000);
        @(negedge clk);
        l2_ack = 1'b0;
        #1 chk("rst_pre_wb", a_vec(), 6'b001000);
        #1 rst_n = 1'b0;
        #1;
        chk("rst_async_vec_a", a_vec(), 6'b000001);
        chk("rst_async_vec_b", b_vec(), 6'b000001);
        chk("rst_async_tag", a_vc_tag_out, '0);
        exp_miss_a = 0; exp_hit_a = 0; exp_miss_b = 0; exp_hit_b = 0;
        chk_counters("rst_async");
        @(negedge clk);
        rst_n = 1'b1;
        idle_cycle("post_rst");

        for (int i = 0; i < 5; i++) begin
            rdata = {$urandom, $urandom, $urandom, $urandom};
            run_miss($sformatf("sat%0d", i), 1'b1, 1'($urandom_range(0, 1)), 1'b1,
                     TL'($urandom), rdata, 1, $urandom_range(1, 2), 1'b0);
        end
        chk("sat_b_hit_cnt", b_vc_hit_cnt, 2'd3);
        chk("sat_b_miss_cnt", b_miss_cnt, 2'd3);

        for (int i = 0; i < 40; i++) begin
            rdata = {$urandom, $urandom, $urandom, $urandom};
            run_miss($sformatf("rnd%0d", i), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                     1'($urandom_range(0, 1)), TL'($urandom), rdata,
                     $urandom_range(1, 4), $urandom_range(1, 3), 1'($urandom_range(0, 1)));
            repeat ($urandom_range(0, 2)) idle_cycle($sformatf("gap%0d", i));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/victim_cache_ctrl.md
Name: victim_cache_ctrl

Overview:
- Sequences L1 miss handling around the L1 victim cache: VC lookup, refill from VC or L2, dirty-victim writeback to L2, victim insertion into VC.
- Sits between the L1 cache controller, the Victim_Cache datapath and the L2 request/ack port.
- Holds the evicted L1 line in an internal swap buffer, so L1 may be refilled before the victim is inserted.
- One miss is serviced at a time.

Parameters:
- SLOT, 4, words per line; power of 2, ≥2
- DATA_LENGTH, 32, word width in bits
- VCTAG_LENGTH, 26, victim-cache tag width in bits
- CNT_WIDTH, 16, width of the saturating statistics counters

Ports:
- clk_l1  in  1  clock; all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- miss_req  in  1  L1 miss request; accepted only when miss_ready=1
- miss_ready  out  1  controller idle and able to accept a request
- victim_valid  in  1  L1 has a valid line to evict; sampled on accept
- victim_dirty  in  1  evicted line is dirty; sampled on accept
- victim_tag  in  VCTAG_LENGTH  tag of the evicted line; sampled on accept
- victim_data  in  SLOT*DATA_LENGTH  evicted line data; sampled on accept
- vc_hit  in  1  Victim_Cache hit for the current miss address
- vc_wen  out  1  one-cycle VC write strobe
- vc_tag_out  out  VCTAG_LENGTH  tag presented to VC tag_in
- vc_data_out  out  SLOT*DATA_LENGTH  line presented to VC data_in
- l2_req  out  1  L2 line fetch request
- l2_ack  in  1  L2 fetch data valid
- wb_req  out  1  L2 writeback request; data taken from vc_data_out
- wb_ack  in  1  L2 writeback accepted
- refill_en  out  1  one-cycle L1 line write strobe
- refill_src  out  1  refill source: 0 = L2, 1 = VC; valid with refill_en
- miss_done  out  1  one-cycle completion pulse
- vc_hit_cnt  out  CNT_WIDTH  saturating count of VC hits
- miss_cnt  out  CNT_WIDTH  saturating count of accepted misses

Behaviour:
- Reset values:
  - state = IDLE; miss_ready = 1.
  - All strobes and requests = 0; refill_src = 0.
  - Counters = 0; swap buffer, hit flag and victim flags cleared.
- IDLE:
  - miss_ready = 1.
  - On miss_req=1, accept: latch victim_valid, victim_dirty, victim_tag, victim_data and vc_hit (into hit_q); increment miss_cnt.
  - Next state: VC_REFILL if vc_hit=1, else L2_FETCH.
  - vc_hit is sampled in the accept cycle only.
- VC_REFILL:
  - One cycle: refill_en=1, refill_src=1; increment vc_hit_cnt.
  - Next state: WB if victim_valid_q and victim_dirty_q; else INSERT if victim_valid_q; else DONE.
- L2_FETCH:
  - l2_req held at 1 until a cycle with l2_ack=1.
  - In that cycle: refill_en=1, refill_src=0, l2_req still 1; l2_req deasserts the next cycle.
  - Next state: same WB/INSERT/DONE selection as VC_REFILL.
  - l2_ack in the same cycle as entry is legal: a one-cycle fetch.
- WB:
  - wb_req held at 1 until wb_ack=1, then INSERT.
  - The dirty victim is written through to L2, so the VC only ever holds clean lines.
- INSERT:
  - One cycle: vc_wen=1, vc_tag_out = tag_q, vc_data_out = buffer; then DONE.
- DONE:
  - One cycle: miss_done=1, then IDLE; miss_ready returns to 1 in the next cycle.
- Ordering: a VC refill always completes before VC insertion. A hit line is therefore read before the FIFO slot can be overwritten, even when that slot is the hitting one.
- vc_tag_out / vc_data_out always drive the swap buffer contents.
- miss_req while busy: ignored, not queued.
- Counters:
  - Saturate at all-ones, no wrap.
  - An increment at saturation holds the value.
- Reset mid-operation: immediately return to IDLE with all outputs at reset values. No partial handshake is resumed.
- Latency, clean miss with victim:
  - VC hit: accept → refill at +1 → insert at +2 → done at +3.
  - L2 miss: refill on the l2_ack cycle, insert +1, done +2.

Decomposition:
- Shared package RVS192_package holds the state typedef vcc_state_e {IDLE, VC_REFILL, L2_FETCH, WB, INSERT, DONE} and constants REFILL_SRC_L2 = 0, REFILL_SRC_VC = 1.
- One sub-module, vc_swap_buffer: SLOT*DATA_LENGTH data plus VCTAG_LENGTH tag register, with load enable and asynchronous clear.

Test Plan:
- Reset, then miss_req=1, vc_hit=1, victim_valid=1, victim_dirty=0, tag=0x155:
  - refill_en with refill_src=1 at cycle 1; vc_wen with tag 0x155 at cycle 2; miss_done at cycle 3.
  - vc_hit_cnt = 1, miss_cnt = 1.
- Miss with vc_hit=0, dirty victim, l2_ack after 3 cycles, wb_ack after 2 cycles:
  - l2_req high 3 cycles; refill_src=0 on the ack cycle.
  - wb_req high 2 cycles, then vc_wen, then miss_done.
  - vc_hit_cnt unchanged.
- Miss with victim_valid=0 and vc_hit=0: no wb_req and no vc_wen; miss_done 1 cycle after the l2_ack cycle.
- miss_req pulsed during L2_FETCH: ignored; miss_cnt incremented exactly once; miss_ready = 0 until after miss_done.
- rst_n asserted low while in WB with wb_req=1: wb_req drops asynchronously; after release state is IDLE, miss_ready = 1, counters = 0.
- Counter saturation (CNT_WIDTH=2): 5 VC-hit misses → vc_hit_cnt = miss_cnt = 3, no wrap.
